// File: rtl/fdivsqrt_pkg.sv
// Shared definitions for the radix-4 divide/square-root on-the-fly converter.
// Holds the converter state encoding, the one-hot digit bit positions and the
// start-of-conversion constants for U, UM and C.
// Initial-value functions return a wide vector. The caller casts the result
// down to its own DIVb+4 datapath width.
package fdivsqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } otfc_state_e;

  // One-hot positions of the signed radix-4 digit inside udigit
  localparam int D2  = 3;
  localparam int D1  = 2;
  localparam int DN1 = 1;
  localparam int DN2 = 0;

  localparam int INIT_W = 128;
  typedef logic [INIT_W-1:0] init_t;

  // Square root: U = 1.0, UM = 0.75, C = ones in [DIVb+3:DIVb-2]
  function automatic init_t sqrt_u_init(int divb);
    return init_t'(1) << divb;
  endfunction

  function automatic init_t sqrt_um_init(int divb);
    return init_t'(3) << (divb - 2);
  endfunction

  function automatic init_t sqrt_c_init(int divb);
    return ~((init_t'(1) << (divb - 2)) - init_t'(1));
  endfunction

  // Divide: U = 0, UM = -4.0, C = ones in [DIVb+3:DIVb]
  function automatic init_t div_u_init(int divb);
    return init_t'(divb) & '0;
  endfunction

  function automatic init_t div_um_init(int divb);
    return init_t'(3) << (divb + 2);
  endfunction

  function automatic init_t div_c_init(int divb);
    return ~((init_t'(1) << divb) - init_t'(1));
  endfunction

endpackage

// File: rtl/fdivsqrt_otfc_step.sv
// Combinational on-the-fly conversion step. Takes the current U, UM and C and
// one radix-4 digit, and produces the next U, UM and C. When more than one
// digit bit is set, the priority is 2 > 1 > -1 > -2.
module fdivsqrt_otfc_step
  import fdivsqrt_pkg::*;
#(
  parameter int DIVb = 58
) (
  input  logic [DIVb+3:0] u_i,
  input  logic [DIVb+3:0] um_i,
  input  logic [DIVb+3:0] c_i,
  input  logic [3:0]      udigit_i,
  output logic [DIVb+3:0] u_o,
  output logic [DIVb+3:0] um_o,
  output logic [DIVb+3:0] c_o
);

  logic [DIVb+3:0] k;

  // One-hot weight of the current digit: the lowest set bit of C
  assign k   = c_i & ~(c_i << 1);
  assign c_o = {2'b11, c_i[DIVb+3:2]};

  // Digit append. Every bit at or below K is zero, so OR acts as addition.
  always_comb begin
    // NOTE: default every output first, so no path through the if-chain
    // leaves one unassigned and infers a latch.
    u_o  = u_i;
    um_o = um_i;
    if (udigit_i[D2]) begin
      u_o  = u_i | (k << 1);
      um_o = u_i | k;
    end else if (udigit_i[D1]) begin
      u_o  = u_i | k;
      um_o = u_i;
    end else if (udigit_i[DN1]) begin
      u_o  = um_i | (k << 1) | k;
      um_o = um_i | (k << 1);
    end else if (udigit_i[DN2]) begin
      u_o  = um_i | (k << 1);
      um_o = um_i | k;
    end else begin
      um_o = um_i | (k << 1) | k;
    end
  end

endmodule

// File: rtl/fdivsqrt_otfc_r4.sv
// Radix-4 on-the-fly quotient/root converter. This module holds the converter
// FSM, the step counter and the U/UM/C registers. The registers feed the
// addend generator.
// Optional feature: define FDIVSQRT_OTFC_DIGIT_CHECK_EN to enable the sticky
// digit_err flag for multi-hot digits. When it is undefined, digit_err is
// tied to 0.
module fdivsqrt_otfc_r4
  import fdivsqrt_pkg::*;
#(
  parameter int DIVb = 58,
  parameter int NW   = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            sqrt_mode,
  input  logic [NW-1:0]   niter,
  input  logic            flush,
  input  logic            step_valid,
  input  logic [3:0]      udigit,
  input  logic            rem_neg,
  output logic [DIVb+3:0] U,
  output logic [DIVb+3:0] UM,
  output logic [DIVb+3:0] C,
  output logic            busy,
  output logic            done,
  output logic [DIVb+3:0] result,
  output logic            digit_err
);

  localparam int W = DIVb + 4;
  localparam logic [W-1:0]  SQRT_U   = W'(sqrt_u_init(DIVb));
  localparam logic [W-1:0]  SQRT_UM  = W'(sqrt_um_init(DIVb));
  localparam logic [W-1:0]  SQRT_C   = W'(sqrt_c_init(DIVb));
  localparam logic [W-1:0]  DIV_U    = W'(div_u_init(DIVb));
  localparam logic [W-1:0]  DIV_UM   = W'(div_um_init(DIVb));
  localparam logic [W-1:0]  DIV_C    = W'(div_c_init(DIVb));
  localparam logic [NW-1:0] MAX_ITER = NW'(DIVb / 2);

  otfc_state_e   state_q;
  logic [W-1:0]  u_q, um_q, c_q;
  logic [W-1:0]  u_d, um_d, c_d;
  logic [NW-1:0] cnt_q, target_q, cnt_inc, niter_clamped;
  logic          busy_q, done_q;
  logic          start_take, step_take;

  assign niter_clamped = (niter > MAX_ITER) ? MAX_ITER : niter;
  assign cnt_inc       = cnt_q + 1'b1;
  assign start_take    = !flush && start && (state_q != BUSY);
  assign step_take     = !flush && step_valid && (state_q == BUSY);

  fdivsqrt_otfc_step #(.DIVb(DIVb)) u_step (
    .u_i      (u_q),
    .um_i     (um_q),
    .c_i      (c_q),
    .udigit_i (udigit),
    .u_o      (u_d),
    .um_o     (um_d),
    .c_o      (c_d)
  );

  // Converter FSM with its registered datapath, step counter and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      u_q      <= '0;
      um_q     <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (flush) begin
      // Abort: go idle and keep the datapath registers as they are
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // pre-edge values and the statement order does not matter.
      case (state_q)
        IDLE, DONE: begin
          if (start_take) begin
            u_q      <= sqrt_mode ? SQRT_U  : DIV_U;
            um_q     <= sqrt_mode ? SQRT_UM : DIV_UM;
            c_q      <= sqrt_mode ? SQRT_C  : DIV_C;
            cnt_q    <= '0;
            target_q <= niter_clamped;
            if (niter_clamped == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= BUSY;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (step_take) begin
            u_q   <= u_d;
            um_q  <= um_d;
            c_q   <= c_d;
            cnt_q <= cnt_inc;
            if (cnt_inc == target_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FDIVSQRT_OTFC_DIGIT_CHECK_EN
  logic digit_err_q;
  logic multi_hot;

  assign multi_hot = |(udigit & (udigit - 4'd1));

  // Sticky flag for an accepted multi-hot digit; only a start clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_err_q <= 1'b0;
    end else if (start_take) begin
      digit_err_q <= 1'b0;
    end else if (step_take && multi_hot) begin
      digit_err_q <= 1'b1;
    end
  end

  assign digit_err = digit_err_q;
`else
  assign digit_err = 1'b0;
`endif

  assign U      = u_q;
  assign UM     = um_q;
  assign C      = c_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = rem_neg ? um_q : u_q;

endmodule

// File: tb/tb_fdivsqrt_otfc_r4.sv
// Directed bench for fdivsqrt_otfc_r4 with DIVb=8. Expected values are worked
// out by hand from the conversion rules.
module tb_fdivsqrt_otfc_r4;

  localparam int DIVb = 8;
  localparam int NW   = 7;
  localparam int W    = DIVb + 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, sqrt_mode, flush, step_valid, rem_neg;
  logic [NW-1:0] niter;
  logic [3:0]    udigit;
  logic [W-1:0]  u, um, c, result;
  logic          busy, done, digit_err;

  int n_checks = 0;
  int n_errors = 0;

  fdivsqrt_otfc_r4 #(.DIVb(DIVb), .NW(NW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .sqrt_mode  (sqrt_mode),
    .niter      (niter),
    .flush      (flush),
    .step_valid (step_valid),
    .udigit     (udigit),
    .rem_neg    (rem_neg),
    .U          (u),
    .UM         (um),
    .C          (c),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .digit_err  (digit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic sq, input logic [NW-1:0] n);
    start = 1'b1; sqrt_mode = sq; niter = n;
    tick();
    start = 1'b0;
  endtask

  task automatic do_step(input logic [3:0] d);
    step_valid = 1'b1; udigit = d;
    tick();
    step_valid = 1'b0; udigit = 4'b0000;
  endtask

  logic exp_err;

  initial begin
`ifdef FDIVSQRT_OTFC_DIGIT_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset_n = 1'b0; start = 1'b0; sqrt_mode = 1'b0; niter = '0;
    flush = 1'b0; step_valid = 1'b0; udigit = 4'b0000; rem_neg = 1'b0;
    #12;
    check("rst_u", 32'(u), 32'h000);
    check("rst_um", 32'(um), 32'h000);
    check("rst_c", 32'(c), 32'h000);
    check("rst_flags", {busy, done, digit_err}, 3'b000);
    check("rst_result", 32'(result), 32'h000);
    reset_n = 1'b1;
    tick();

    // Square-root initialisation and two digits
    do_start(1'b1, 7'd4);
    check("sq_init_u", 32'(u), 32'h100);
    check("sq_init_um", 32'(um), 32'h0C0);
    check("sq_init_c", 32'(c), 32'hFC0);
    check("sq_busy", {busy, done}, 2'b10);
    do_step(4'b1000);
    check("sq_d2_u", 32'(u), 32'h180);
    check("sq_d2_um", 32'(um), 32'h140);
    check("sq_d2_c", 32'(c), 32'hFF0);
    do_step(4'b0010);
    check("sq_dn1_u", 32'(u), 32'h170);
    check("sq_dn1_um", 32'(um), 32'h160);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_flags", {busy, done}, 2'b00);
    check("flush_hold_u", 32'(u), 32'h170);

    // Divide, niter=3, step_valid gaps between digits
    do_start(1'b0, 7'd3);
    check("dv_init_u", 32'(u), 32'h000);
    check("dv_init_um", 32'(um), 32'hC00);
    check("dv_init_c", 32'(c), 32'hF00);
    do_step(4'b0100);
    check("dv_d1_u", 32'(u), 32'h100);
    check("dv_d1_um", 32'(um), 32'h000);
    tick();
    check("dv_gap_u", 32'(u), 32'h100);
    check("dv_gap_busy", {busy, done}, 2'b10);
    do_step(4'b0000);
    check("dv_d0_u", 32'(u), 32'h100);
    check("dv_d0_um", 32'(um), 32'h0C0);
    check("dv_d0_done", done, 1'b0);
    tick();
    do_step(4'b0100);
    check("dv_done", {busy, done}, 2'b01);
    check("dv_final_u", 32'(u), 32'h110);
    check("dv_final_um", 32'(um), 32'h100);
    check("res_pos", 32'(result), 32'h110);
    rem_neg = 1'b1;
    #1;
    check("res_neg", 32'(result), 32'h100);
    rem_neg = 1'b0;
    do_step(4'b1000);
    check("extra_ignored_u", 32'(u), 32'h110);
    check("extra_done", done, 1'b1);

    // niter=0 from DONE: done on the start edge, initial values
    do_start(1'b1, 7'd0);
    check("n0_flags", {busy, done}, 2'b01);
    check("n0_u", 32'(u), 32'h100);
    check("n0_um", 32'(um), 32'h0C0);

    // niter=127 clamps to 4 digits
    do_start(1'b0, 7'd127);
    check("clamp_busy", {busy, done}, 2'b10);
    do_step(4'b0000);
    do_step(4'b0000);
    do_step(4'b0000);
    check("clamp_not_done", done, 1'b0);
    do_step(4'b0000);
    check("clamp_done", {busy, done}, 2'b01);
    check("clamp_u", 32'(u), 32'h000);
    check("clamp_um", 32'(um), 32'hFFC);
    check("clamp_c", 32'(c), 32'hFFF);

    // Asynchronous reset in the middle of a conversion
    do_start(1'b1, 7'd4);
    do_step(4'b1000);
    reset_n = 1'b0;
    #1;
    check("mid_rst_u", 32'(u), 32'h000);
    check("mid_rst_c", 32'(c), 32'h000);
    check("mid_rst_flags", {busy, done}, 2'b00);
    #2;
    reset_n = 1'b1;
    tick();

    // Flush together with start: idle, registers held
    do_start(1'b0, 7'd2);
    do_step(4'b0100);
    flush = 1'b1; start = 1'b1; sqrt_mode = 1'b1; niter = 7'd1;
    tick();
    flush = 1'b0; start = 1'b0;
    check("fs_flags", {busy, done}, 2'b00);
    check("fs_hold_u", 32'(u), 32'h100);
    check("fs_hold_um", 32'(um), 32'h000);
    check("fs_hold_c", 32'(c), 32'hFC0);
    do_start(1'b1, 7'd1);
    check("fs_restart_um", 32'(um), 32'h0C0);
    check("fs_restart_c", 32'(c), 32'hFC0);
    do_step(4'b1000);
    check("fs_restart_done", {busy, done}, 2'b01);
    check("fs_restart_u", 32'(u), 32'h180);
    check("fs_restart_um2", 32'(um), 32'h140);

    // Multi-hot digit: digit 1 wins, flag follows the build option
    do_start(1'b0, 7'd2);
    check("err_clear0", digit_err, 1'b0);
    do_step(4'b0110);
    check("mh_u", 32'(u), 32'h100);
    check("mh_um", 32'(um), 32'h000);
    check("mh_err", digit_err, exp_err);
    do_step(4'b0000);
    check("mh_err_sticky", digit_err, exp_err);
    do_start(1'b0, 7'd2);
    check("err_cleared", digit_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fdivsqrt_otfc_r4.md
# fdivsqrt_otfc_r4

Radix-4 on-the-fly quotient/root converter for the divide/square-root unit. It accumulates signed radix-4 digits {2, 1, 0, -1, -2} from the digit-selection logic into two registers: U (partial result) and UM (partial result minus one unit in the last place). It also holds the position mask C that marks the current digit weight. The registered U, UM and C feed the addend generator on the next iteration, and the final U/UM select yields the result.

## Interface
- DIVb, default 58: fraction bits; all datapath registers are DIVb+4 bits, Q4.DIVb two's complement, bit DIVb = 1.0.
- NW, default 7: width of iteration count; must satisfy 2^NW > DIVb/2.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin conversion; honoured only in IDLE or DONE.
- sqrt_mode  in  1  1 = square root initialisation, 0 = divide; sampled with start.
- niter  in  NW  number of digits to accept; sampled with start; values above DIVb/2 are clamped to DIVb/2.
- flush  in  1  abort; highest priority.
- step_valid  in  1  udigit is valid this cycle.
- udigit  in  4  one-hot {2, 1, -1, -2} in bits [3:0]; all zero = digit 0.
- rem_neg  in  1  final remainder negative; used only in DONE.
- U, UM, C  out  DIVb+4 each  registered state for the addend generator.
- busy  out  1  state is BUSY.
- done  out  1  state is DONE.
- result  out  DIVb+4  rem_neg ? UM : U; meaningful only while done.
- digit_err  out  1  sticky illegal-digit flag (see Configuration).

## Operation
- States: IDLE, BUSY, DONE.
  - IDLE→BUSY on start (DONE if niter=0).
  - BUSY→DONE on the edge that accepts the niter-th digit.
  - DONE→BUSY on start; DONE otherwise holds.
  - Any state→IDLE on flush.
- Mask rules: K = C & ~(C<<1), a one-hot weight of the current digit. Each accepted step updates C = {2'b11, C[DIVb+3:2]}.
- Sqrt start loads:
  - U = 1.0 (bit DIVb)
  - UM = 0.75 (bits DIVb-1, DIVb-2)
  - C = ones in [DIVb+3:DIVb-2]
- Divide start loads:
  - U = 0
  - UM = -4.0 (bits [DIVb+3:DIVb+2])
  - C = ones in [DIVb+3:DIVb]
- Per accepted digit d (bitwise OR suffices, since all bits at and below the K position are zero):
  - d=2: U=U|K<<1, UM=U|K
  - d=1: U=U|K, UM=U
  - d=0: U=U, UM=UM|K<<1|K
  - d=-1: U=UM|K<<1|K, UM=UM|K<<1
  - d=-2: U=UM|K<<1, UM=UM|K
- An internal step counter (NW bits) clears on start and increments per accepted digit.
- Ignored inputs:
  - step_valid outside BUSY.
  - start while BUSY.
- flush together with start: flush wins, and U/UM/C hold.

## Timing
- Reset values: state IDLE; U, UM, C, counter all zero; busy=0; done=0; digit_err=0. result is therefore 0.
- start sampled at edge n: initial U/UM/C are visible after edge n; busy=1 from edge n.
- Digit accepted at edge m: updated U/UM/C are visible after edge m, so the addend generator sees them in cycle m+1.
- Gaps in step_valid stall the conversion with no state change.
- With continuous step_valid, done rises exactly niter cycles after the start edge.
- Latency start→done = niter accepted steps.
- Reset asserted mid-conversion returns to reset values immediately, with no completion.

## Configuration
- FDIVSQRT_OTFC_DIGIT_CHECK_EN defined: digit_err sets on any accepted step whose udigit has more than one bit high. It is cleared only by start or reset. The illegal digit is still applied with the priority order 2 > 1 > -1 > -2.
- Macro undefined: the check logic is absent, digit_err is tied 0, and the priority order still applies.

## Structure
- Shared fdivsqrt package holds:
  - the state enum {IDLE, BUSY, DONE}
  - the digit one-hot bit positions (D2=3, D1=2, DN1=1, DN2=0)
  - initial-value constants for sqrt/divide U, UM, C, as functions of DIVb
- One sub-module, fdivsqrt_otfc_step: combinational next-U/UM/C from (U, UM, C, udigit). The top holds the FSM, counter, registers and check.

## Test plan
- DIVb=8, sqrt start → U=0x100, UM=0x0C0, C=0xFC0; digit 2 → U=0x180, UM=0x140, C=0xFF0; digit -1 → U=0x170, UM=0x160.
- DIVb=8, divide start → U=0x000, UM=0xC00, C=0xF00; digit 1 → U=0x100, UM=0x000; digit 0 → U=0x100, UM=0x0C0.
- niter=3 with step_valid toggling every other cycle: done rises after the 3rd accepted digit. The 4th digit is ignored, and result switches U↔UM with rem_neg.
- niter=0: done one edge after start with U/UM at their initial values. niter=127 with DIVb=8: clamped, done after 4 digits.
- Reset mid-BUSY and flush+start in the same cycle → IDLE/zero outputs and IDLE with registers held, respectively. A new start then converts correctly.
- With the macro defined, udigit=4'b0110 sets digit_err and applies digit 1; the next start clears digit_err. With the macro undefined, digit_err stays 0.
